// File: rtl/proc_multi_param.sv
// proc_multi_param: parametrised multi-cycle processor core (T0..T3 control FSM,
// NREG general registers, A/G ALU registers, zero/carry flags, shared bus).
// Optional feature macro: PROC_LOGIC_OPS_EN enables AND/OR/XOR; without it the
// opcodes 100/101/110 are reported as Illegal and no logic-op hardware exists.
module proc_multi_param #(
  parameter int DW  = 16,
  parameter int RAW = 3
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Run,
  input  logic [DW-1:0] DIN,
  output logic          Done,
  output logic          Busy,
  output logic          Illegal,
  output logic          Zflag,
  output logic          Cflag,
  output logic [DW-1:0] BusWires
);

  localparam int NREG = 2**RAW;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
`ifdef PROC_LOGIC_OPS_EN
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
`endif
  localparam logic [2:0] OP_MVNZ = 3'b111;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_REG  = 2'd1,
    SRC_G    = 2'd2,
    SRC_DIN  = 2'd3
  } src_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   ir_q, ir_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   g_q, g_d;
  logic            z_q, z_d;
  logic            c_q, c_d;
  logic [DW-1:0]   regs_q [NREG];

  logic [2:0]      opcode_s;
  logic [RAW-1:0]  rx_s;
  logic [RAW-1:0]  ry_s;
  logic            is_alu_s;
  src_e            src_s;
  logic [RAW-1:0]  src_reg_s;
  logic [DW-1:0]   bus_s;
  logic            reg_we_s;
  logic            a_we_s;
  logic            g_we_s;
  logic            done_s;
  logic            illegal_s;
  logic [DW:0]     alu_res_s;

  assign opcode_s = ir_q[DW-1 -: 3];
  assign rx_s     = ir_q[2*RAW-1 -: RAW];
  assign ry_s     = ir_q[RAW-1:0];

  // IR bits between the opcode and the X field carry no meaning
  if (DW - 3 > 2*RAW) begin : g_ir_gap
    logic unused_ir_gap_s;
    assign unused_ir_gap_s = ^ir_q[DW-4:2*RAW];
  end

  // Classify the opcode as a three-step ALU instruction
  always_comb begin
    is_alu_s = 1'b0;
    case (opcode_s)
      OP_ADD:  is_alu_s = 1'b1;
      OP_SUB:  is_alu_s = 1'b1;
`ifdef PROC_LOGIC_OPS_EN
      OP_AND:  is_alu_s = 1'b1;
      OP_OR:   is_alu_s = 1'b1;
      OP_XOR:  is_alu_s = 1'b1;
`endif
      default: is_alu_s = 1'b0;
    endcase
  end

  // Control decode: next state, IR load, bus source and write enables
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    src_s     = SRC_NONE;
    src_reg_s = ry_s;
    reg_we_s  = 1'b0;
    a_we_s    = 1'b0;
    g_we_s    = 1'b0;
    done_s    = 1'b0;
    illegal_s = 1'b0;
    case (state_q)
      T0: begin
        if (Run) begin
          ir_d    = DIN;
          state_d = T1;
        end else begin
          state_d = T0;
        end
      end
      T1: begin
        if (is_alu_s) begin
          src_s     = SRC_REG;
          src_reg_s = rx_s;
          a_we_s    = 1'b1;
          state_d   = T2;
        end else begin
          done_s  = 1'b1;
          state_d = T0;
          case (opcode_s)
            OP_MV: begin
              src_s    = SRC_REG;
              reg_we_s = 1'b1;
            end
            OP_MVI: begin
              src_s    = SRC_DIN;
              reg_we_s = 1'b1;
            end
            OP_MVNZ: begin
              // Move only while the last ALU result was non-zero
              if (!z_q) begin
                src_s    = SRC_REG;
                reg_we_s = 1'b1;
              end else begin
                src_s    = SRC_NONE;
                reg_we_s = 1'b0;
              end
            end
            default: illegal_s = 1'b1;
          endcase
        end
      end
      T2: begin
        src_s   = SRC_REG;
        g_we_s  = 1'b1;
        state_d = T3;
      end
      T3: begin
        src_s    = SRC_G;
        reg_we_s = 1'b1;
        done_s   = 1'b1;
        state_d  = T0;
      end
      default: state_d = T0;
    endcase
  end

  // Bus multiplexer: one source at a time, zero when idle
  always_comb begin
    bus_s = {DW{1'b0}};
    case (src_s)
      SRC_REG: bus_s = regs_q[src_reg_s];
      SRC_G:   bus_s = g_q;
      SRC_DIN: bus_s = DIN;
      default: bus_s = {DW{1'b0}};
    endcase
  end

  // ALU: A op bus with the carry/borrow in the extra top bit
  always_comb begin
    alu_res_s = {(DW+1){1'b0}};
    case (opcode_s)
      OP_ADD:  alu_res_s = {1'b0, a_q} + {1'b0, bus_s};
      OP_SUB:  alu_res_s = {1'b0, a_q} - {1'b0, bus_s};
`ifdef PROC_LOGIC_OPS_EN
      OP_AND:  alu_res_s = {1'b0, a_q & bus_s};
      OP_OR:   alu_res_s = {1'b0, a_q | bus_s};
      OP_XOR:  alu_res_s = {1'b0, a_q ^ bus_s};
`endif
      default: alu_res_s = {(DW+1){1'b0}};
    endcase
  end

  // Datapath next values for A, G and the flags
  always_comb begin
    a_d = a_q;
    g_d = g_q;
    z_d = z_q;
    c_d = c_q;
    if (a_we_s) begin
      a_d = bus_s;
    end else begin
      a_d = a_q;
    end
    if (g_we_s) begin
      g_d = alu_res_s[DW-1:0];
      z_d = (alu_res_s[DW-1:0] == {DW{1'b0}});
      c_d = alu_res_s[DW];
    end else begin
      g_d = g_q;
      z_d = z_q;
      c_d = c_q;
    end
  end

  // Control and datapath registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= T0;
      ir_q    <= {DW{1'b0}};
      a_q     <= {DW{1'b0}};
      g_q     <= {DW{1'b0}};
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  // General register file, written from the bus
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {DW{1'b0}};
      end
    end else if (reg_we_s) begin
      regs_q[rx_s] <= bus_s;
    end
  end

  assign Done     = done_s;
  assign Busy     = (state_q != T0);
  assign Illegal  = illegal_s;
  assign Zflag    = z_q;
  assign Cflag    = c_q;
  assign BusWires = bus_s;

endmodule

// File: tb/tb_proc_multi_param.sv
// tb_proc_multi_param: directed plus random instruction stream for
// proc_multi_param, checked cycle by cycle against an architectural model
// (register array and flags updated with plain arithmetic per instruction).
module tb_proc_multi_param;

  localparam int DW   = 16;
  localparam int RAW  = 3;
  localparam int NREG = 8;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_MVNZ = 3'b111;

  logic          Clock = 1'b0;
  logic          Resetn;
  logic          Run;
  logic [DW-1:0] DIN;
  logic          Done;
  logic          Busy;
  logic          Illegal;
  logic          Zflag;
  logic          Cflag;
  logic [DW-1:0] BusWires;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_reg [NREG];
  logic          m_z;
  logic          m_c;

  proc_multi_param #(.DW(DW), .RAW(RAW)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .Run      (Run),
    .DIN      (DIN),
    .Done     (Done),
    .Busy     (Busy),
    .Illegal  (Illegal),
    .Zflag    (Zflag),
    .Cflag    (Cflag),
    .BusWires (BusWires)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_alu(input logic [2:0] op);
`ifdef PROC_LOGIC_OPS_EN
    return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR});
`else
    return (op inside {OP_ADD, OP_SUB});
`endif
  endfunction

  function automatic logic [DW-1:0] enc(input logic [2:0] op, input logic [RAW-1:0] x,
                                        input logic [RAW-1:0] y);
    logic [6:0] junk;
    junk = 7'($urandom);
    return {op, junk, x, y};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NREG; k++) m_reg[k] = 16'h0000;
    m_z = 1'b0;
    m_c = 1'b0;
  endtask

  // Executes one instruction from T0, checking every cycle; returns in the next T0
  task automatic run_instr(input logic [2:0] op, input logic [RAW-1:0] x,
                           input logic [RAW-1:0] y, input logic [DW-1:0] imm,
                           input logic hold);
    logic [DW-1:0] rx, ry, res, exp_bus;
    logic          c, ill;
    int unsigned   s;
    rx = m_reg[x];
    ry = m_reg[y];
    Run = 1'b1;
    DIN = enc(op, x, y);
    @(negedge Clock);
    chk("t0_busy", Busy, 16'd0);
    chk("t0_done", Done, 16'd0);
    chk("t0_bus", BusWires, 16'd0);
    chk("t0_z", Zflag, m_z);
    chk("t0_c", Cflag, m_c);
    @(posedge Clock); #1;
    Run = hold;
    DIN = (op == OP_MVI) ? imm : DW'($urandom);
    @(negedge Clock);
    chk("t1_busy", Busy, 16'd1);
    if (is_alu(op)) begin
      chk("t1_done", Done, 16'd0);
      chk("t1_illegal", Illegal, 16'd0);
      chk("t1_bus", BusWires, rx);
      @(posedge Clock); #1;
      DIN = DW'($urandom);
      @(negedge Clock);
      chk("t2_bus", BusWires, ry);
      chk("t2_done", Done, 16'd0);
      chk("t2_busy", Busy, 16'd1);
      c = 1'b0;
      case (op)
        OP_ADD: begin
          s   = int'(rx) + int'(ry);
          res = DW'(s);
          c   = (s > 32'h0000_FFFF);
        end
        OP_SUB: begin
          res = rx - ry;
          c   = (rx < ry);
        end
        OP_AND:  res = rx & ry;
        OP_OR:   res = rx | ry;
        default: res = rx ^ ry;
      endcase
      @(posedge Clock); #1;
      @(negedge Clock);
      chk("t3_bus", BusWires, res);
      chk("t3_done", Done, 16'd1);
      chk("t3_busy", Busy, 16'd1);
      chk("t3_z", Zflag, {15'd0, (res == 16'h0000)});
      chk("t3_c", Cflag, {15'd0, c});
      m_reg[x] = res;
      m_z = (res == 16'h0000);
      m_c = c;
    end else begin
      chk("t1_done", Done, 16'd1);
      ill = 1'b0;
      case (op)
        OP_MV: begin
          exp_bus  = ry;
          m_reg[x] = ry;
        end
        OP_MVI: begin
          exp_bus  = imm;
          m_reg[x] = imm;
        end
        OP_MVNZ: begin
          exp_bus = m_z ? 16'h0000 : ry;
          if (!m_z) m_reg[x] = ry;
        end
        default: begin
          exp_bus = 16'h0000;
          ill     = 1'b1;
        end
      endcase
      chk("t1_bus", BusWires, exp_bus);
      chk("t1_illegal", Illegal, {15'd0, ill});
    end
    @(posedge Clock); #1;
    Run = 1'b0;
  endtask

  // Reads every register through MV Rk,Rk (bus shows Rk in T1)
  task automatic check_all();
    for (int k = 0; k < NREG; k++) begin
      run_instr(OP_MV, RAW'(k), RAW'(k), 16'h0000, 1'($urandom));
    end
  endtask

  initial begin
    Resetn = 1'b0;
    Run    = 1'b0;
    DIN    = 16'h0000;
    model_reset();
    #12;
    chk("rst_busy", Busy, 16'd0);
    chk("rst_done", Done, 16'd0);
    chk("rst_illegal", Illegal, 16'd0);
    chk("rst_bus", BusWires, 16'd0);
    chk("rst_z", Zflag, 16'd0);
    chk("rst_c", Cflag, 16'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    @(posedge Clock); #1;

    run_instr(OP_MVI, 3'd0, 3'd0, 16'h1234, 1'b0);
    run_instr(OP_MV,  3'd5, 3'd0, 16'h0000, 1'b1);
    run_instr(OP_MV,  3'd5, 3'd5, 16'h0000, 1'b0);

    run_instr(OP_MVI, 3'd1, 3'd0, 16'hFFFF, 1'b0);
    run_instr(OP_MVI, 3'd2, 3'd0, 16'h0001, 1'b0);
    run_instr(OP_ADD, 3'd1, 3'd2, 16'h0000, 1'b1);
    chk("add_z", Zflag, 16'd1);
    chk("add_c", Cflag, 16'd1);
    run_instr(OP_MVNZ, 3'd7, 3'd0, 16'h0000, 1'b0);
    run_instr(OP_MV,   3'd7, 3'd7, 16'h0000, 1'b0);

    run_instr(OP_MVI, 3'd3, 3'd0, 16'h0005, 1'b0);
    run_instr(OP_MVI, 3'd4, 3'd0, 16'h0007, 1'b0);
    run_instr(OP_SUB, 3'd3, 3'd4, 16'h0000, 1'b1);
    chk("sub_z", Zflag, 16'd0);
    chk("sub_c", Cflag, 16'd1);
    run_instr(OP_MVNZ, 3'd6, 3'd3, 16'h0000, 1'b1);
    run_instr(OP_MV,   3'd6, 3'd6, 16'h0000, 1'b0);

    run_instr(OP_ADD, 3'd4, 3'd4, 16'h0000, 1'b0);
    run_instr(OP_SUB, 3'd1, 3'd1, 16'h0000, 1'b0);
    chk("subself_z", Zflag, 16'd1);
    chk("subself_c", Cflag, 16'd0);

`ifdef PROC_LOGIC_OPS_EN
    run_instr(OP_MVI, 3'd1, 3'd0, 16'h00FF, 1'b0);
    run_instr(OP_MVI, 3'd2, 3'd0, 16'h0F0F, 1'b0);
    run_instr(OP_XOR, 3'd1, 3'd2, 16'h0000, 1'b1);
    run_instr(OP_MV,  3'd1, 3'd1, 16'h0000, 1'b0);
`else
    run_instr(OP_XOR, 3'd1, 3'd2, 16'h0000, 1'b1);
    run_instr(OP_AND, 3'd3, 3'd4, 16'h0000, 1'b0);
    check_all();
`endif

    for (int n = 0; n < 60; n++) begin
      run_instr(3'($urandom), RAW'($urandom), RAW'($urandom), DW'($urandom), 1'($urandom));
    end
    check_all();

    // Abort an ADD in T2 with an asynchronous reset
    Run = 1'b1;
    DIN = enc(OP_ADD, 3'd1, 3'd2);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    #2;
    Resetn = 1'b0;
    Run    = 1'b0;
    #1;
    chk("abort_busy", Busy, 16'd0);
    chk("abort_done", Done, 16'd0);
    chk("abort_bus", BusWires, 16'd0);
    chk("abort_z", Zflag, 16'd0);
    chk("abort_c", Cflag, 16'd0);
    model_reset();
    @(negedge Clock);
    Resetn = 1'b1;
    @(posedge Clock); #1;
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/proc_multi_param.md
Name: proc_multi_param

Overview:
- Parametrised successor of the 9-bit multi-cycle processor.
- Data width and register count are configurable. The instruction set adds MVNZ plus logic ops. Zero/carry flags are added, along with Busy and Illegal status outputs.
- Sits as the datapath+control core fed by an instruction/data source on DIN. Run starts an instruction; Done marks its final cycle.
- BusWires exposes the internal bus for observation.

Parameters:
- DW, 16, data/bus width in bits; must satisfy DW >= 3 + 2*RAW.
- RAW, 3, register address width; NREG = 2**RAW general registers R0..R(NREG-1).

Ports:
- Clock  in  1  system clock, rising edge
- Resetn  in  1  asynchronous active-low reset
- Run  in  1  start request, sampled only in T0
- DIN  in  DW  instruction (in T0) or immediate (in T1 of MVI)
- Done  out  1  high during the final cycle of an instruction
- Busy  out  1  high in T1..T3
- Illegal  out  1  one-cycle pulse in T1 for an unsupported opcode
- Zflag  out  1  G result == 0, from last ALU op
- Cflag  out  1  carry (ADD) / borrow (SUB) from last ALU op
- BusWires  out  DW  current bus value

Behaviour:
- One clock (Clock); reset is asynchronous and active-low (Resetn).
- Instruction fields:
  - IR[DW-1:DW-3] = opcode.
  - IR[2*RAW-1:RAW] = X.
  - IR[RAW-1:0] = Y.
  - Bits between the fields are ignored.
- Opcodes: 000 MV, 001 MVI, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 MVNZ.
- Reset:
  - State T0.
  - All Rn, A, G, IR = 0; Zflag = Cflag = 0.
  - Done = Busy = Illegal = 0; BusWires = 0.
  - Reset mid-instruction aborts it with no register write.
- FSM states T0, T1, T2, T3:
  - T0: IR <= DIN only when Run=1, then go to T1; otherwise stay in T0 and IR holds.
  - T1, single-cycle ops (MV, MVI, MVNZ, illegal): Done=1, then go to T0.
  - T1, ALU ops: go to T2.
  - T2 -> T3 -> T0 unconditionally.
- Run is ignored outside T0. Back-to-back: a new Run is accepted in the T0 immediately following a Done cycle.
- Bus source is exactly one of Rn, G, DIN; when no source is selected the bus reads 0.
- Per-instruction actions:
  - MV (T1): bus=RY, RX<=bus.
  - MVI (T1): bus=DIN, RX<=DIN.
  - MVNZ (T1): if Zflag=0, bus=RY and RX<=RY; otherwise no write. Done in both cases.
  - ALU ops, T1: bus=RX, A<=bus.
  - ALU ops, T2: bus=RY, G<=A op bus; flags update here.
  - ALU ops, T3: bus=G, RX<=G, Done=1.
- Arithmetic:
  - ADD: result mod 2**DW; Cflag = carry out of bit DW-1.
  - SUB: A-RY mod 2**DW; Cflag = 1 iff A<RY unsigned.
  - AND/OR/XOR: bitwise; Cflag = 0.
  - Zflag = (G next == 0) for every ALU op.
  - Non-ALU instructions leave the flags unchanged.
- X==Y is legal:
  - ADD R1,R1 doubles R1.
  - SUB R1,R1 gives 0 with Z=1, C=0.
- Done, Busy and Illegal are decoded combinationally from state and IR; they are not registered.

Optional Feature:
- Macro PROC_LOGIC_OPS_EN.
- Defined: AND/OR/XOR behave as above (4 cycles including T0).
- Undefined:
  - Opcodes 100/101/110 are illegal.
  - In T1: Illegal=1, Done=1, no register or flag change, return to T0.
  - No logic-op hardware is instantiated.

Test Plan (DW=16, RAW=3):
- Reset, then MVI R0,0x1234 then MV R5,R0 -> R0=R5=0x1234; Done high in each T1; Busy low in T0.
- MVI R1,0xFFFF; MVI R2,0x0001; ADD R1,R2 -> R1=0x0000, Z=1, C=1; Done asserted in T3 only.
- MVI R3,0x0005; MVI R4,0x0007; SUB R3,R4 -> R3=0xFFFE, C=1, Z=0. Then MVNZ R6,R3 -> R6=0xFFFE.
- Reach Z=1, then MVNZ R7,R0 -> R7 unchanged; Done=1 in T1.
- Opcode 110 with logic ops disabled -> Illegal and Done pulse in T1, no state change. With logic ops enabled, XOR 0x00FF^0x0F0F -> 0x0FF0.
- Assert Resetn=0 during T2 of ADD -> immediate T0, all registers 0. Run held high during T1..T3 -> no extra IR load.
